// File: rtl/firstband_predictor_multimode.sv
// First-band predictor: consumes a raster-scanned block of samples over
// AXI-Stream and emits, per sample, a prediction (average, left or MED)
// paired with the original sample through a one-entry output register.
// Optional feature macro: FIRSTBAND_PREDICTOR_MED_EN. When it is defined,
// mode 1 selects the MED (LOCO-I) predictor. When it is undefined, the
// up-left register and the comparators are left out and mode 1 predicts
// exactly like mode 0 (average).
module firstband_predictor_multimode #(
    parameter int DATA_WIDTH          = 16,
    parameter int BLOCK_WIDTH_LOG_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  x_valid,
    output logic                  x_ready,
    input  logic [DATA_WIDTH-1:0] x_data,
    input  logic                  x_last_row,
    input  logic                  x_last_slice,
    output logic                  xtilde_valid,
    input  logic                  xtilde_ready,
    output logic [DATA_WIDTH-1:0] xtilde_data,
    output logic [DATA_WIDTH-1:0] xtilde_x,
    output logic                  xtilde_last,
    output logic                  err_overflow,
    output logic                  err_width
);

    localparam int DEPTH = 1 << BLOCK_WIDTH_LOG_MAX;
    localparam int CW    = BLOCK_WIDTH_LOG_MAX;

    typedef enum logic {
        IDLE_BLOCK,
        IN_BLOCK
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] rowbuf [DEPTH];
    logic [CW-1:0]         col;
    logic [CW:0]           row0_len;
    logic [CW:0]           row_len;
    logic                  first_row;
    logic                  wrap_pending;
    logic [1:0]            mode_reg;
    logic [1:0]            mode_eff;
    logic [DATA_WIDTH-1:0] left_val;
    logic [DATA_WIDTH-1:0] up_val;
    logic [DATA_WIDTH-1:0] avg_val;
    logic [DATA_WIDTH-1:0] pred;
    logic                  accept;
    logic                  first_of_block;
    logic                  end_of_row;
    logic                  col_at_max;

`ifdef FIRSTBAND_PREDICTOR_MED_EN
    logic [DATA_WIDTH-1:0] up_left_val;
    logic [DATA_WIDTH-1:0] max_ab;
    logic [DATA_WIDTH-1:0] min_ab;
    logic [DATA_WIDTH-1:0] med_val;
`endif

    assign x_ready        = !rst && (!xtilde_valid || xtilde_ready);
    assign accept         = x_valid && x_ready;
    assign first_of_block = (state == IDLE_BLOCK);
    assign end_of_row     = x_last_row || x_last_slice;
    assign col_at_max     = &col;
    assign row_len        = {1'b0, col} + (CW+1)'(1);
    assign up_val         = rowbuf[col];
    assign mode_eff       = first_of_block ? mode : mode_reg;
    assign avg_val        = DATA_WIDTH'(({1'b0, left_val} + {1'b0, up_val}) >> 1);

    // Block state register: idle until the first sample of a block arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE_BLOCK;
        end else begin
            state <= state_next;
        end
    end

    // Block FSM next state: a last_slice sample always closes the block
    always_comb begin
        state_next = state;
        case (state)
            IDLE_BLOCK: if (accept && !x_last_slice) state_next = IN_BLOCK;
            IN_BLOCK:   if (accept && x_last_slice)  state_next = IDLE_BLOCK;
            default:    state_next = IDLE_BLOCK;
        endcase
    end

`ifdef FIRSTBAND_PREDICTOR_MED_EN
    // MED predictor: clamp toward min/max of left and up, else planar estimate
    always_comb begin
        max_ab  = (left_val > up_val) ? left_val : up_val;
        min_ab  = (left_val > up_val) ? up_val : left_val;
        med_val = DATA_WIDTH'({1'b0, left_val} + {1'b0, up_val} - {1'b0, up_left_val});
        if (up_left_val >= max_ab) begin
            med_val = min_ab;
        end else if (up_left_val <= min_ab) begin
            med_val = max_ab;
        end
    end
`endif

    // Prediction select: boundary rules first, then the latched interior mode
    always_comb begin
        pred = '0;
        if (wrap_pending) begin
            pred = up_val;
        end else if (first_row) begin
            pred = (col == '0) ? '0 : left_val;
        end else if (col == '0) begin
            pred = up_val;
        end else begin
            case (mode_eff)
                2'd2:    pred = left_val;
`ifdef FIRSTBAND_PREDICTOR_MED_EN
                2'd1:    pred = med_val;
`endif
                default: pred = avg_val;
            endcase
        end
    end

    // Row buffer: the up neighbour is read before this sample overwrites it
    always_ff @(posedge clk) begin
        if (accept) begin
            rowbuf[col] <= x_data;
        end
    end

    // Output register, neighbour history, row/column tracking and sticky errors
    always_ff @(posedge clk) begin
        if (rst) begin
            xtilde_valid <= 1'b0;
            xtilde_data  <= '0;
            xtilde_x     <= '0;
            xtilde_last  <= 1'b0;
            err_overflow <= 1'b0;
            err_width    <= 1'b0;
            col          <= '0;
            row0_len     <= '0;
            first_row    <= 1'b1;
            wrap_pending <= 1'b0;
            mode_reg     <= '0;
            left_val     <= '0;
`ifdef FIRSTBAND_PREDICTOR_MED_EN
            up_left_val  <= '0;
`endif
        end else if (accept) begin
            xtilde_valid <= 1'b1;
            xtilde_data  <= pred;
            xtilde_x     <= x_data;
            xtilde_last  <= x_last_slice;
            left_val     <= x_data;
`ifdef FIRSTBAND_PREDICTOR_MED_EN
            up_left_val  <= up_val;
`endif
            if (first_of_block) begin
                mode_reg <= mode;
            end
            if (wrap_pending) begin
                err_overflow <= 1'b1;
            end
            wrap_pending <= !end_of_row && col_at_max;
            if (end_of_row) begin
                col <= '0;
                if (first_row) begin
                    row0_len <= row_len;
                end else if (row_len != row0_len) begin
                    err_width <= 1'b1;
                end
            end else begin
                col <= col + CW'(1);
            end
            if (x_last_slice) begin
                first_row <= 1'b1;
            end else if (x_last_row) begin
                first_row <= 1'b0;
            end
        end else if (xtilde_ready) begin
            xtilde_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_firstband_predictor_multimode.sv
// Testbench for firstband_predictor_multimode: table-driven 4x2 blocks in
// every mode, plus hand-written backpressure, width-mismatch, reset and
// overflow sequences.
module tb_firstband_predictor_multimode;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic        x_valid;
    logic        x_ready;
    logic [15:0] x_data;
    logic        x_last_row;
    logic        x_last_slice;
    logic        xtilde_valid;
    logic        xtilde_ready;
    logic [15:0] xtilde_data;
    logic [15:0] xtilde_x;
    logic        xtilde_last;
    logic        err_overflow;
    logic        err_width;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        logic        last_row;
        logic        last_slice;
        logic [1:0]  mode;
        logic [15:0] exp_pred;
    } vec_t;

    vec_t vecs[$];

    int rowData[8]  = '{10, 20, 30, 40, 12, 22, 32, 42};
    int avgExp[8]   = '{0, 10, 20, 30, 10, 16, 26, 36};
    int leftExp[8]  = '{0, 10, 20, 30, 10, 12, 22, 32};
`ifdef FIRSTBAND_PREDICTOR_MED_EN
    int medExp[8]   = '{0, 10, 20, 30, 10, 20, 30, 40};
`else
    int medExp[8]   = '{0, 10, 20, 30, 10, 16, 26, 36};
`endif
    int midModes[8] = '{0, 2, 2, 1, 3, 2, 2, 1};

    firstband_predictor_multimode #(
        .DATA_WIDTH          (16),
        .BLOCK_WIDTH_LOG_MAX (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .x_data       (x_data),
        .x_last_row   (x_last_row),
        .x_last_slice (x_last_slice),
        .xtilde_valid (xtilde_valid),
        .xtilde_ready (xtilde_ready),
        .xtilde_data  (xtilde_data),
        .xtilde_x     (xtilde_x),
        .xtilde_last  (xtilde_last),
        .err_overflow (err_overflow),
        .err_width    (err_width)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input int d, input int lr, input int ls,
                                   input int m, input int e);
        vec_t v;
        v.data       = 16'(d);
        v.last_row   = (lr != 0);
        v.last_slice = (ls != 0);
        v.mode       = 2'(m);
        v.exp_pred   = 16'(e);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one sample, expect it accepted this cycle and visible one cycle later
    task automatic applyStimulus(input vec_t v, input string tag);
        x_valid      = 1'b1;
        x_data       = v.data;
        x_last_row   = v.last_row;
        x_last_slice = v.last_slice;
        mode         = v.mode;
        checkOutput({tag, ".x_ready"}, 32'(x_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput({tag, ".valid"}, 32'(xtilde_valid), 32'd1);
        checkOutput({tag, ".pred"},  32'(xtilde_data),  32'(v.exp_pred));
        checkOutput({tag, ".x"},     32'(xtilde_x),     32'(v.data));
        checkOutput({tag, ".last"},  32'(xtilde_last),  32'(v.last_slice));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".x_ready"},  32'(x_ready),      32'd0);
        checkOutput({tag, ".valid"},    32'(xtilde_valid), 32'd0);
        checkOutput({tag, ".data"},     32'(xtilde_data),  32'd0);
        checkOutput({tag, ".x"},        32'(xtilde_x),     32'd0);
        checkOutput({tag, ".last"},     32'(xtilde_last),  32'd0);
        checkOutput({tag, ".overflow"}, 32'(err_overflow), 32'd0);
        checkOutput({tag, ".width"},    32'(err_width),    32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        mode         = 2'd0;
        x_valid      = 1'b0;
        x_data       = '0;
        x_last_row   = 1'b0;
        x_last_slice = 1'b0;
        xtilde_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b0;
        #1;
        checkOutput("post_reset_x_ready", 32'(x_ready), 32'd1);

        // Four back-to-back 4x2 blocks: average, MED, left, average with mode toggling
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                int m;
                int e;
                case (b)
                    0: begin m = 0; e = avgExp[i]; end
                    1: begin m = 1; e = medExp[i]; end
                    2: begin m = 2; e = leftExp[i]; end
                    default: begin m = midModes[i]; e = avgExp[i]; end
                endcase
                vecs.push_back(mkVec(rowData[i], (i == 3 || i == 7) ? 1 : 0,
                                     (i == 7) ? 1 : 0, m, e));
            end
        end
        foreach (vecs[k]) begin
            applyStimulus(vecs[k], $sformatf("blk%0d_s%0d", k / 8, k % 8));
        end
        x_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("drain_valid", 32'(xtilde_valid), 32'd0);

        // Backpressure mid-row: output held, input stalled, nothing lost
        applyStimulus(mkVec(100, 0, 0, 0, 0),   "bp_s0");
        applyStimulus(mkVec(200, 0, 0, 0, 100), "bp_s1");
        applyStimulus(mkVec(300, 0, 0, 0, 200), "bp_s2");
        applyStimulus(mkVec(400, 1, 0, 0, 300), "bp_s3");
        applyStimulus(mkVec(110, 0, 0, 0, 100), "bp_s4");
        xtilde_ready = 1'b0;
        x_valid      = 1'b1;
        x_data       = 16'd210;
        x_last_row   = 1'b0;
        x_last_slice = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_stall_x_ready", 32'(x_ready),      32'd0);
            checkOutput("bp_stall_valid",   32'(xtilde_valid), 32'd1);
            checkOutput("bp_stall_data",    32'(xtilde_data),  32'd100);
            checkOutput("bp_stall_x",       32'(xtilde_x),     32'd110);
        end
        xtilde_ready = 1'b1;
        #1;
        applyStimulus(mkVec(210, 0, 0, 0, 155), "bp_s5");
        applyStimulus(mkVec(310, 0, 0, 0, 255), "bp_s6");
        applyStimulus(mkVec(410, 1, 1, 0, 355), "bp_s7");
        x_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("bp_drain_valid", 32'(xtilde_valid), 32'd0);

        // Width mismatch: row 0 has 4 samples, row 1 only 3
        applyStimulus(mkVec(1, 0, 0, 0, 0), "wd_s0");
        applyStimulus(mkVec(2, 0, 0, 0, 1), "wd_s1");
        applyStimulus(mkVec(3, 0, 0, 0, 2), "wd_s2");
        applyStimulus(mkVec(4, 1, 0, 0, 3), "wd_s3");
        applyStimulus(mkVec(5, 0, 0, 0, 1), "wd_s4");
        applyStimulus(mkVec(6, 0, 0, 0, 3), "wd_s5");
        checkOutput("wd_before", 32'(err_width), 32'd0);
        applyStimulus(mkVec(7, 1, 0, 0, 4), "wd_s6");
        checkOutput("wd_after", 32'(err_width), 32'd1);
        applyStimulus(mkVec(8, 0, 0, 0, 5), "wd_s7");

        // Reset mid-block clears everything and restarts the block
        x_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("midrst");
        rst = 1'b0;
        #1;
        applyStimulus(mkVec(77, 0, 1, 0, 0), "midrst_first");

        // Overflow: 17 samples with no row end; 17th uses the up rule
        for (int i = 0; i < 17; i++) begin
            int e;
            if (i == 0) e = 0;
            else if (i == 16) e = 1000;
            else e = 1000 + i - 1;
            applyStimulus(mkVec(1000 + i, 0, (i == 16) ? 1 : 0, 0, e),
                          $sformatf("ov_s%0d", i));
            if (i == 15) checkOutput("ov_before", 32'(err_overflow), 32'd0);
        end
        checkOutput("ov_after", 32'(err_overflow), 32'd1);
        x_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(mkVec(5, 0, 1, 2, 0), "ov_next_block");
        checkOutput("ov_sticky", 32'(err_overflow), 32'd1);
        x_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ov_cleared", 32'(err_overflow), 32'd0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/firstband_predictor_multimode.md
Name: firstband_predictor_multimode

Overview:
- Parametrised successor to the LCPLC first-band predictor.
- Accepts a raster-scanned block of first-band samples over AXI-Stream. Rows are delimited by x_last_row; the block is delimited by x_last_slice.
- For each sample it emits the prediction xtilde, paired with the original sample, using a per-block selectable mode: average, left, or MED (LOCO-I).
- Sits between the block reader and the first-band error/quantiser stage, so downstream needs no separate x delay FIFO.

Parameters:
- DATA_WIDTH, 16, sample width in bits (unsigned).
- BLOCK_WIDTH_LOG_MAX, 4, log2 of the maximum row length; sets row buffer depth to 2^BLOCK_WIDTH_LOG_MAX.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mode  in  2  prediction mode: 0=average, 1=MED, 2=left, 3=reserved (treated as 0); sampled with the first sample of each block
- x_valid  in  1  input handshake
- x_ready  out  1  input handshake
- x_data  in  DATA_WIDTH  input sample
- x_last_row  in  1  sample is the last of its row
- x_last_slice  in  1  sample is the last of the block
- xtilde_valid  out  1  output handshake
- xtilde_ready  in  1  output handshake
- xtilde_data  out  DATA_WIDTH  prediction
- xtilde_x  out  DATA_WIDTH  original sample paired with the prediction
- xtilde_last  out  1  registered copy of x_last_slice
- err_overflow  out  1  sticky: row exceeded 2^BLOCK_WIDTH_LOG_MAX samples
- err_width  out  1  sticky: a row length differs from row 0 of the same block

Behaviour:
- Reset values: all outputs 0; x_ready is 0 during reset and 1 on the first cycle after.
- Internal state on reset: col=0, first_row=1, first_of_block=1. Row buffer contents are don't-care.
- Reset mid-block discards in-flight data and restarts at the block start.
- Output register, one entry. Latency is one cycle from input handshake to xtilde_valid.
- x_ready = !xtilde_valid || xtilde_ready.
- Output fields (data, x, last) are held stable while xtilde_valid && !xtilde_ready.
- Neighbours:
  - a = left (previous sample in the row).
  - b = up, read from rowbuf[col].
  - c = up-left (b of the previous column, registered).
  - On each accepted sample, rowbuf[col] <= x_data after the read.
- Boundary rules (all modes):
  - Row 0, col 0: prediction 0.
  - Row 0, col > 0: a.
  - Row > 0, col 0: b.
- Interior rules:
  - mode 0 (average): (a+b)>>1, computed at DATA_WIDTH+1 bits, truncating.
  - mode 2 (left): a.
  - mode 1 (MED): if c >= max(a,b) then min(a,b); else if c <= min(a,b) then max(a,b); else a+b-c. The result is always in range, so no saturation is needed.
- mode is latched when first_of_block is accepted and held until the xtilde_last sample is accepted. Changes to mode mid-block are ignored.
- Counters and row state:
  - col increments per accepted sample and resets to 0 on last_row or last_slice.
  - x_last_slice implies end of row even if x_last_row is 0.
  - After last_slice: first_row=1 and first_of_block=1. err flags are NOT cleared; they clear only on rst.
  - Row 0's length is latched at its last_row. Each later row's length is compared to it; a mismatch sets err_width, and processing continues with stale/undefined up values.
  - If col would wrap past 2^BLOCK_WIDTH_LOG_MAX-1 without last_row: set err_overflow, col wraps to 0, and that sample is treated as starting a new row (no first_row change).
- Simultaneous input accept and output drain in the same cycle is sustained at full throughput, one sample/cycle.
- FSM with 2 states:
  - IDLE_BLOCK: awaiting the first sample.
  - IN_BLOCK: after the first sample is accepted; returns to IDLE_BLOCK on acceptance of a last_slice sample.

Optional Feature:
- Macro FIRSTBAND_PREDICTOR_MED_EN.
- Defined: mode 1 uses MED; the up-left register and MED comparator logic are synthesised.
- Undefined: the up-left register and comparators are removed, and mode 1 behaves exactly as mode 0 (average). All other behaviour is unchanged.

Test Plan:
- Average, 4x2 block: rows [10,20,30,40],[12,22,32,42], mode=0, ready always high -> xtilde = 0,10,20,30,10,16,26,36; xtilde_last only on the 8th output; 1 sample/cycle.
- MED, same data, mode=1 (macro defined) -> 0,10,20,30,10,20,30,40. With the macro undefined -> identical to the average result.
- Left, same data, mode=2 -> 0,10,20,30,10,12,22,32. Then a second block with mode=0 sent immediately -> first output 0 (row state reset); mode toggled mid-block has no effect.
- Backpressure: xtilde_ready low for 5 cycles mid-row -> xtilde_data/xtilde_x unchanged, x_ready low after one further accept, no sample lost or duplicated (output compared against golden file).
- Overflow: 17 samples with x_last_row=0 (BLOCK_WIDTH_LOG_MAX=4) -> err_overflow rises on the 17th accept and stays 1 until rst; prediction for the 17th sample = b rule.
- Width mismatch and reset: row0 width 4, row1 width 3 -> err_width=1 after row1's last_row. Assert rst mid-block -> all outputs 0, err flags cleared, next sample predicted as 0.
